gshare_predictor: RTL and testbench

- Parametrised branch direction predictor.
- Holds a table of 2^IDX_W saturating counters, each CTR_W bits wide.
- The table is indexed by PC bits, optionally XORed with a global history register (gshare mode), or by PC bits alone (bimodal mode).
- Sits beside the fetch stage: fetch issues a lookup, and the execute stage returns the resolved outcome as an update.

---
 rtl/gshare_predictor.sv | 100 ++++++++++
 tb/tb_gshare_predictor.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/gshare_predictor.sv
// Gshare / bimodal branch direction predictor: a table of saturating counters
// indexed by PC (optionally XORed with global history), plus a mispredict count.
module gshare_predictor #(
  parameter int unsigned IDX_W     = 6,
  parameter int unsigned CTR_W     = 2,
  parameter int unsigned HIST_W    = 6,
  parameter int unsigned GSHARE_EN = 1,
  parameter int unsigned STAT_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              lk_req,
  input  logic [IDX_W-1:0]  lk_pc,
  output logic              lk_vld,
  output logic              lk_taken,
  output logic [IDX_W-1:0]  lk_idx,
  input  logic              up_vld,
  input  logic [IDX_W-1:0]  up_idx,
  input  logic              up_taken,
  input  logic              up_pred,
  input  logic              stat_clr,
  output logic [HIST_W-1:0] hist,
  output logic [STAT_W-1:0] mispred_cnt
);

  localparam int unsigned        ENTRIES  = 1 << IDX_W;
  localparam logic [CTR_W-1:0]   CTR_MAX  = '1;
  localparam logic [CTR_W-1:0]   CTR_INIT = CTR_W'((1 << (CTR_W - 1)) - 1);
  localparam logic [STAT_W-1:0]  STAT_MAX = '1;

  logic [CTR_W-1:0]  ctr_q [ENTRIES];
  logic [HIST_W-1:0] hist_q, hist_d;
  logic [STAT_W-1:0] mis_q, mis_d;
  logic              lk_vld_q, lk_taken_q, lk_taken_d;
  logic [IDX_W-1:0]  lk_idx_q, lk_idx_d;
  logic [CTR_W-1:0]  up_ctr_c, ctr_upd_c;

  // Index formation, saturating counter step, history shift and statistic.
  always_comb begin
    lk_idx_d   = lk_pc;
    lk_taken_d = lk_taken_q;
    up_ctr_c   = ctr_q[up_idx];
    ctr_upd_c  = up_ctr_c;
    hist_d     = hist_q;
    mis_d      = mis_q;

    if (GSHARE_EN != 0) begin
      lk_idx_d = lk_pc ^ IDX_W'(hist_q);
    end
    lk_taken_d = ctr_q[lk_idx_d][CTR_W-1];

    if (up_taken && (up_ctr_c != CTR_MAX)) begin
      ctr_upd_c = up_ctr_c + CTR_W'(1);
    end else if (!up_taken && (up_ctr_c != '0)) begin
      ctr_upd_c = up_ctr_c - CTR_W'(1);
    end

    if (up_vld) begin
      hist_d = HIST_W'({hist_q, up_taken});
    end

    if (stat_clr) begin
      mis_d = '0;
    end else if (up_vld && (up_taken != up_pred) && (mis_q != STAT_MAX)) begin
      mis_d = mis_q + STAT_W'(1);
    end
  end

  // Lookup reads ctr_q before this edge's write, giving read-before-write on collision.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(ENTRIES); i++) begin
        ctr_q[i] <= CTR_INIT;
      end
      hist_q     <= '0;
      mis_q      <= '0;
      lk_vld_q   <= 1'b0;
      lk_taken_q <= 1'b0;
      lk_idx_q   <= '0;
    end else begin
      if (up_vld) begin
        ctr_q[up_idx] <= ctr_upd_c;
      end
      hist_q   <= hist_d;
      mis_q    <= mis_d;
      lk_vld_q <= lk_req;
      if (lk_req) begin
        lk_taken_q <= lk_taken_d;
        lk_idx_q   <= lk_idx_d;
      end
    end
  end

  assign lk_vld      = lk_vld_q;
  assign lk_taken    = lk_taken_q;
  assign lk_idx      = lk_idx_q;
  assign hist        = hist_q;
  assign mispred_cnt = mis_q;

endmodule

// File: tb/tb_gshare_predictor.sv
// Directed plus randomized bench for gshare_predictor: gshare, bimodal and
// narrow-statistic instances share one stimulus and one behavioural model.
module tb_gshare_predictor;

  localparam int IDX_W = 6;
  localparam int CTR_W = 2;
  localparam int HIST_W = 6;
  localparam int ENT = 1 << IDX_W;
  localparam int CTR_TOP = (1 << CTR_W) - 1;
  localparam int CTR_HALF = 1 << (CTR_W - 1);

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic lk_req = 1'b0;
  logic [IDX_W-1:0] lk_pc = '0;
  logic up_vld = 1'b0;
  logic [IDX_W-1:0] up_idx = '0;
  logic up_taken = 1'b0;
  logic up_pred = 1'b0;
  logic stat_clr = 1'b0;

  logic g_vld, g_tk, b_vld, b_tk, s_vld, s_tk;
  logic [IDX_W-1:0] g_idx, b_idx, s_idx;
  logic [HIST_W-1:0] g_hist, b_hist, s_hist;
  logic [15:0] g_mis, b_mis;
  logic [2:0] s_mis;

  always #5 clk = ~clk;

  gshare_predictor #(.IDX_W(IDX_W), .CTR_W(CTR_W), .HIST_W(HIST_W), .GSHARE_EN(1), .STAT_W(16)) u_g (
    .clk(clk), .reset(reset), .lk_req(lk_req), .lk_pc(lk_pc), .lk_vld(g_vld), .lk_taken(g_tk),
    .lk_idx(g_idx), .up_vld(up_vld), .up_idx(up_idx), .up_taken(up_taken), .up_pred(up_pred),
    .stat_clr(stat_clr), .hist(g_hist), .mispred_cnt(g_mis));

  gshare_predictor #(.IDX_W(IDX_W), .CTR_W(CTR_W), .HIST_W(HIST_W), .GSHARE_EN(0), .STAT_W(16)) u_b (
    .clk(clk), .reset(reset), .lk_req(lk_req), .lk_pc(lk_pc), .lk_vld(b_vld), .lk_taken(b_tk),
    .lk_idx(b_idx), .up_vld(up_vld), .up_idx(up_idx), .up_taken(up_taken), .up_pred(up_pred),
    .stat_clr(stat_clr), .hist(b_hist), .mispred_cnt(b_mis));

  gshare_predictor #(.IDX_W(IDX_W), .CTR_W(CTR_W), .HIST_W(HIST_W), .GSHARE_EN(1), .STAT_W(3)) u_s (
    .clk(clk), .reset(reset), .lk_req(lk_req), .lk_pc(lk_pc), .lk_vld(s_vld), .lk_taken(s_tk),
    .lk_idx(s_idx), .up_vld(up_vld), .up_idx(up_idx), .up_taken(up_taken), .up_pred(up_pred),
    .stat_clr(stat_clr), .hist(s_hist), .mispred_cnt(s_mis));

  // Behavioural model: counters as plain integers, history as an integer shift.
  int m_ctr [ENT];
  int m_hist, m_mis16, m_mis3;
  int e_vld, e_idx_g, e_idx_b, e_tk_g, e_tk_b;
  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < ENT; i++) m_ctr[i] = CTR_HALF - 1;
    m_hist = 0; m_mis16 = 0; m_mis3 = 0;
    e_vld = 0; e_idx_g = 0; e_idx_b = 0; e_tk_g = 0; e_tk_b = 0;
  endtask

  task automatic check_all();
    chk("g_vld", 32'(g_vld), 32'(e_vld));
    chk("b_vld", 32'(b_vld), 32'(e_vld));
    chk("g_idx", 32'(g_idx), 32'(e_idx_g));
    chk("b_idx", 32'(b_idx), 32'(e_idx_b));
    chk("g_taken", 32'(g_tk), 32'(e_tk_g));
    chk("b_taken", 32'(b_tk), 32'(e_tk_b));
    chk("s_taken", 32'(s_tk), 32'(e_tk_g));
    chk("g_hist", 32'(g_hist), 32'(m_hist));
    chk("b_hist", 32'(b_hist), 32'(m_hist));
    chk("g_mis", 32'(g_mis), 32'(m_mis16));
    chk("s_mis", 32'(s_mis), 32'(m_mis3));
  endtask

  // One clock of stimulus; inputs change on the falling edge, outputs checked on the next.
  task automatic step(input bit req, input int pc, input bit uv, input int uidx,
                      input bit ut, input bit up, input bit clr);
    lk_req = req; lk_pc = IDX_W'(pc); up_vld = uv; up_idx = IDX_W'(uidx);
    up_taken = ut; up_pred = up; stat_clr = clr;
    e_vld = req;
    if (req) begin
      e_idx_g = (pc ^ m_hist) % ENT;
      e_idx_b = pc % ENT;
      e_tk_g = (m_ctr[e_idx_g] >= CTR_HALF) ? 1 : 0;
      e_tk_b = (m_ctr[e_idx_b] >= CTR_HALF) ? 1 : 0;
    end
    if (uv) begin
      if (ut && m_ctr[uidx] < CTR_TOP) m_ctr[uidx] = m_ctr[uidx] + 1;
      if (!ut && m_ctr[uidx] > 0) m_ctr[uidx] = m_ctr[uidx] - 1;
      m_hist = (m_hist * 2 + (ut ? 1 : 0)) % (1 << HIST_W);
    end
    if (clr) begin
      m_mis16 = 0; m_mis3 = 0;
    end else if (uv && ut != up) begin
      if (m_mis16 < 65535) m_mis16++;
      if (m_mis3 < 7) m_mis3++;
    end
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0);
  endtask

  // Reset pulse away from any clock edge; outputs must clear before the next edge.
  task automatic pulse_reset();
    #2 reset = 1'b0;
    #1;
    chk("rst_vld", 32'(g_vld), 32'd0);
    chk("rst_taken", 32'(g_tk), 32'd0);
    chk("rst_idx", 32'(g_idx), 32'd0);
    chk("rst_hist", 32'(g_hist), 32'd0);
    chk("rst_mis", 32'(g_mis), 32'd0);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    check_all();
    reset = 1'b1;

    // Basic lookup after reset
    step(1, 5, 0, 0, 0, 0, 0);
    chk("first_idx", 32'(g_idx), 32'd5);
    chk("first_taken", 32'(g_tk), 32'd0);
    step(1, 9, 1, 5, 1, 1, 0);
    step(0, 0, 1, 9, 1, 0, 0);
    pulse_reset();

    // Saturation upward then downward at entry 5
    for (int i = 0; i < 3; i++) step(0, 0, 1, 5, 1, 1, 0);
    step(1, 5, 0, 0, 0, 0, 0);
    chk("sat_up_taken_b", 32'(b_tk), 32'd1);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 5, 0, 0, 0);
    step(1, 5, 0, 0, 0, 0, 0);
    chk("sat_dn_taken_b", 32'(b_tk), 32'd0);
    idle();
    chk("hold_idx_b", 32'(b_idx), 32'd5);

    // Hysteresis: strongly taken, one not-taken still predicts taken
    pulse_reset();
    for (int i = 0; i < 3; i++) step(0, 0, 1, 7, 1, 1, 0);
    step(0, 0, 1, 7, 0, 1, 0);
    step(1, 7, 0, 0, 0, 0, 0);
    chk("hyst_taken_b", 32'(b_tk), 32'd1);

    // History pattern 1,0,1 and gshare vs bimodal index
    pulse_reset();
    step(0, 0, 1, 32, 1, 1, 0);
    step(0, 0, 1, 32, 0, 0, 0);
    step(0, 0, 1, 32, 1, 1, 0);
    chk("hist_101", 32'(g_hist), 32'h05);
    step(1, 15, 0, 0, 0, 0, 0);
    chk("gshare_idx", 32'(g_idx), 32'h0A);
    chk("bimodal_idx", 32'(b_idx), 32'h0F);
    chk("bimodal_hist", 32'(b_hist), 32'h05);

    // Same-cycle lookup and update of entry 3
    pulse_reset();
    step(1, 3, 1, 3, 1, 1, 0);
    chk("coll_taken_g", 32'(g_tk), 32'd0);
    chk("coll_taken_b", 32'(b_tk), 32'd0);
    step(1, 3, 0, 0, 0, 0, 0);
    chk("coll_after_b", 32'(b_tk), 32'd1);

    // Mispredict statistic, saturation on the narrow instance, clear priority
    pulse_reset();
    for (int i = 0; i < 5; i++) step(0, 0, 1, i, i % 2, (i + 1) % 2, 0);
    chk("mis5", 32'(g_mis), 32'd5);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 10, 1, 0, 0);
    chk("mis9", 32'(g_mis), 32'd9);
    chk("mis9_sat3", 32'(s_mis), 32'd7);
    step(0, 0, 1, 10, 0, 1, 1);
    chk("mis_clr", 32'(g_mis), 32'd0);
    chk("mis_clr3", 32'(s_mis), 32'd0);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      step(1'($urandom_range(0, 1)), int'($urandom_range(0, ENT - 1)),
           1'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 15) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
